fifo_wr_arbiter: RTL

- Round-robin write arbiter that shares the 8-bit, 4-entry synchronous FIFO write port between NUM_REQ producers.
- Each producer uses a valid/ready handshake. The block drives the FIFO data_in and write_enable inputs and honours the FIFO full flag.
- A granted producer keeps ownership for up to BURST_LEN accepted words, so bursts stay contiguous in the FIFO.
- Sits between producer logic and the FIFO, in the same clk domain.

---
 rtl/fifo_wr_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ valid/ready producers, with burst locking.
// Latency: zero; the grantee's word is written into the FIFO on the same clk edge that accepts it.
// Backpressure: fifo_full drops req_ready and write_enable, and the current grant and burst count are held.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4,
    parameter int ID_W      = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic [DATA_W-1:0]         fifo_data_in,
    output logic                      fifo_write_enable,
    output logic                      grant_valid,
    output logic [ID_W-1:0]           grant_id
);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state;
    logic [ID_W-1:0]    owner;
    logic [ID_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]   burst_cnt;

    logic [ID_W-1:0]    search_sel;
    logic [ID_W:0]      probe;
    logic               found;
    logic [ID_W-1:0]    cur;
    logic               gnt;
    logic               any_valid;
    logic               cur_valid;
    logic               accept;

    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] x);
        return (x == ID_W'(NUM_REQ - 1)) ? '0 : x + 1'b1;
    endfunction

    // Circular search from rr_ptr; the explicit subtract keeps the wrap correct for non-power-of-2 NUM_REQ.
    always_comb begin
        search_sel = '0;
        found      = 1'b0;
        probe      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            probe = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (probe >= (ID_W+1)'(NUM_REQ)) begin
                probe = probe - (ID_W+1)'(NUM_REQ);
            end
            if (!found && req_valid[probe[ID_W-1:0]]) begin
                found      = 1'b1;
                search_sel = probe[ID_W-1:0];
            end
        end
    end

    assign any_valid = |req_valid;
    assign cur       = (state == BURST) ? owner : search_sel;
    // rst_n gates the combinational outputs so nothing leaks out while reset is held.
    assign gnt       = rst_n & ((state == BURST) | any_valid);
    assign cur_valid = req_valid[cur];
    assign accept    = gnt & cur_valid & ~fifo_full;

    assign grant_valid       = gnt;
    assign grant_id          = gnt ? cur : '0;
    assign fifo_write_enable = accept;

    always_comb begin
        req_ready    = '0;
        fifo_data_in = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt && cur == ID_W'(i)) begin
                req_ready[i] = ~fifo_full;
                fifo_data_in = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        if (accept && BURST_LEN == 1) begin
                            rr_ptr <= next_idx(cur);
                        end else begin
                            // The grant locks even when the FIFO is full, so the burst owner is fixed early.
                            state     <= BURST;
                            owner     <= cur;
                            burst_cnt <= accept ? CNT_W'(1) : '0;
                        end
                    end
                end
                BURST: begin
                    if (!cur_valid) begin
                        state     <= IDLE;
                        rr_ptr    <= next_idx(owner);
                        burst_cnt <= '0;
                    end else if (accept) begin
                        if (burst_cnt == CNT_W'(BURST_LEN - 1)) begin
                            state     <= IDLE;
                            rr_ptr    <= next_idx(owner);
                            burst_cnt <= '0;
                        end else begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
